// File: rtl/ysyx_22041412_muldiv.sv
// ---------------------------------------------------------------------------
// ysyx_22041412_muldiv
// Multi-cycle multiply/divide unit for the EXU. It covers the eight M-extension
// func3 operations plus the RV64 word (*W) forms. Multiplies use an iterative
// shift-add datapath and divides use a restoring divider. Both retire UNROLL
// bits per cycle.
//
// Parameters
//   XLEN    datapath width, 32 or 64
//   UNROLL  bits retired per iteration, 1, 2 or 4
//
// Ports
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset
//   in_valid    issue request valid
//   in_ready    unit can accept a request this cycle
//   in_func3    M-extension func3 (MUL..REMU)
//   in_word     word (*W) operation, only meaningful when XLEN is 64
//   rs1, rs2    operand A / dividend and operand B / divisor
//   flush       kill whatever is in flight
//   out_valid   result valid
//   out_ready   consumer takes the result
//   out_result  result value, zero whenever no result is being offered
//   busy        unit is not idle
// ---------------------------------------------------------------------------
module ysyx_22041412_muldiv #(
   parameter int XLEN   = 64,
   parameter int UNROLL = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_func3,
   input  logic            in_word,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic            busy
);

   localparam int CW = $clog2(XLEN / UNROLL + 1);
   localparam logic [CW-1:0] ITER_FULL = CW'(XLEN / UNROLL);
   localparam logic [CW-1:0] ITER_WORD = CW'(32 / UNROLL);
   localparam bit HAS_WORD = (XLEN == 64);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      func3_q, func3_d;
   logic            word_q, word_d;
   logic            negRes_q, negRes_d;
   logic            negRem_q, negRem_d;
   logic [XLEN-1:0] mcand_q, mcand_d;
   logic [XLEN-1:0] hi_q, hi_d;
   logic [XLEN-1:0] lo_q, lo_d;
   logic [XLEN-1:0] result_q, result_d;

   // Take the low 32 bits of a value and widen them to XLEN, either
   // sign-extending or zero-extending.
   function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
      logic [XLEN-1:0] r;
      r = {XLEN{sgn & v[31]}};
      r[31:0] = v;
      return r;
   endfunction

   // Issue-side decode. Operands are first narrowed for word ops, then split
   // into magnitude and sign so that the iterative datapath is purely
   // unsigned. Divide-by-zero and signed overflow are recognised here so
   // that they can bypass the iteration entirely.
   logic            wordEff;
   logic            signedA, signedB;
   logic            signA, signB;
   logic            isDivIn, divZero, divOvf, special;
   logic [XLEN-1:0] opA, opB, magA, magB, mostNeg, spRaw, spRes;

   always_comb begin
      wordEff = HAS_WORD & in_word;
      signedA = (in_func3 == 3'b001) | (in_func3 == 3'b010) |
                (in_func3 == 3'b100) | (in_func3 == 3'b110);
      signedB = (in_func3 == 3'b001) | (in_func3 == 3'b100) | (in_func3 == 3'b110);
      opA = wordEff ? ext32(rs1[31:0], signedA) : rs1;
      opB = wordEff ? ext32(rs2[31:0], signedB) : rs2;
      signA = signedA & opA[XLEN-1];
      signB = signedB & opB[XLEN-1];
      magA = signA ? -opA : opA;
      magB = signB ? -opB : opB;
      mostNeg = wordEff ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
      isDivIn = in_func3[2];
      divZero = isDivIn & (opB == '0);
      divOvf  = isDivIn & ~in_func3[0] & (opA == mostNeg) & (opB == '1);
      special = divZero | divOvf;
      if (divZero) begin
         spRaw = in_func3[1] ? opA : '1;
      end else begin
         spRaw = in_func3[1] ? '0 : opA;
      end
      spRes = wordEff ? ext32(spRaw[31:0], 1'b1) : spRaw;
   end

   // One CALC cycle worth of work for both datapaths. The multiplier keeps
   // the partial product in hi and shifts the multiplier out of lo, so the
   // product ends up in {hi, lo}. The divider shifts the dividend out of the
   // top of lo into the remainder in hi and shifts quotient bits into the
   // bottom of lo.
   logic [XLEN:0]   mulSum, divTrial, divDiff;
   logic [XLEN-1:0] mulHi, mulLo, divRem, divQuo;

   always_comb begin
      mulHi  = hi_q;
      mulLo  = lo_q;
      mulSum = '0;
      for (int k = 0; k < UNROLL; k++) begin
         mulSum = {1'b0, mulHi} + (mulLo[0] ? {1'b0, mcand_q} : '0);
         mulLo  = {mulSum[0], mulLo[XLEN-1:1]};
         mulHi  = mulSum[XLEN:1];
      end
      divRem   = hi_q;
      divQuo   = lo_q;
      divTrial = '0;
      divDiff  = '0;
      for (int k = 0; k < UNROLL; k++) begin
         divTrial = {divRem, divQuo[XLEN-1]};
         divDiff  = divTrial - {1'b0, mcand_q};
         divRem   = divDiff[XLEN] ? divTrial[XLEN-1:0] : divDiff[XLEN-1:0];
         divQuo   = {divQuo[XLEN-2:0], ~divDiff[XLEN]};
      end
   end

   // Final fix-up once iteration is finished: restore the signs and pick
   // the requested half or the quotient/remainder. A word multiply only ran
   // 32 steps, so its low product bits sit at the top of lo. Word forms of
   // the high multiplies are undefined upstream and simply return zero.
   logic [2*XLEN-1:0] fixProd;
   logic [XLEN-1:0]   fixQuo, fixRem, divRes, mulRes, fixResult;

   always_comb begin
      fixQuo = negRes_q ? -lo_q : lo_q;
      fixRem = negRem_q ? -hi_q : hi_q;
      divRes = func3_q[1] ? fixRem : fixQuo;
      if (word_q) begin
         divRes = ext32(divRes[31:0], 1'b1);
      end
      fixProd = {hi_q, lo_q};
      if (negRes_q) begin
         fixProd = -fixProd;
      end
      if (word_q) begin
         mulRes = (func3_q[1:0] == 2'b00) ? ext32(lo_q[XLEN-1 -: 32], 1'b1) : '0;
      end else begin
         mulRes = (func3_q[1:0] == 2'b00) ? fixProd[XLEN-1:0] : fixProd[2*XLEN-1:XLEN];
      end
      fixResult = func3_q[2] ? divRes : mulRes;
   end

   // Next-state logic. Flush beats everything, including a pending accept
   // and the result pop. The result register is cleared whenever the unit
   // leaves DONE so that the output reads zero while idle.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      func3_d  = func3_q;
      word_d   = word_q;
      negRes_d = negRes_q;
      negRem_d = negRem_q;
      mcand_d  = mcand_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      result_d = result_q;
      if (flush) begin
         state_d  = IDLE;
         result_d = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid && in_ready) begin
                  func3_d  = in_func3;
                  word_d   = wordEff;
                  cnt_d    = wordEff ? ITER_WORD : ITER_FULL;
                  negRes_d = signA ^ signB;
                  hi_d     = '0;
                  if (isDivIn) begin
                     mcand_d  = magB;
                     lo_d     = wordEff ? (magA << (XLEN - 32)) : magA;
                     negRem_d = signA;
                  end else begin
                     mcand_d  = magA;
                     lo_d     = magB;
                     negRem_d = 1'b0;
                  end
                  if (special) begin
                     state_d  = DONE;
                     result_d = spRes;
                  end else begin
                     state_d = CALC;
                  end
               end
            end
            CALC: begin
               hi_d = func3_q[2] ? divRem : mulHi;
               lo_d = func3_q[2] ? divQuo : mulLo;
               if (cnt_q == CW'(1)) begin
                  state_d = FIX;
               end
               cnt_d = cnt_q - CW'(1);
            end
            FIX: begin
               result_d = fixResult;
               state_d  = DONE;
            end
            DONE: begin
               if (out_ready) begin
                  state_d  = IDLE;
                  result_d = '0;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and datapath registers. Reset clears everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         func3_q  <= '0;
         word_q   <= 1'b0;
         negRes_q <= 1'b0;
         negRem_q <= 1'b0;
         mcand_q  <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         func3_q  <= func3_d;
         word_q   <= word_d;
         negRes_q <= negRes_d;
         negRem_q <= negRem_d;
         mcand_q  <= mcand_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         result_q <= result_d;
      end
   end

   // Handshake and status outputs
   always_comb begin
      in_ready   = (state_q == IDLE) & ~flush;
      out_valid  = (state_q == DONE);
      busy       = (state_q != IDLE);
      out_result = result_q;
   end

endmodule

// File: tb/tb_ysyx_22041412_muldiv.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22041412_muldiv
// Self-checking bench for the multiply/divide unit at XLEN=64, UNROLL=1.
// Expected results come from a plain-arithmetic reference model. Latencies
// come from the documented cycle counts.
// ---------------------------------------------------------------------------
module tb_ysyx_22041412_muldiv;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_func3;
   logic        in_word;
   logic [63:0] rs1;
   logic [63:0] rs2;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_result;
   logic        busy;

   int errors;
   int checks;

   localparam int LAT_FULL = 66;
   localparam int LAT_WORD = 34;
   localparam int LAT_SPECIAL = 1;

   ysyx_22041412_muldiv #(.XLEN(64), .UNROLL(1)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_func3   (in_func3),
      .in_word    (in_word),
      .rs1        (rs1),
      .rs2        (rs2),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .busy       (busy)
   );

   // Free-running clock with a 10-unit period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something wedges beyond the per-wait bounds
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [63:0] sx32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   // Reference model: the architected result of each operation, computed
   // with ordinary integer arithmetic on the operand values.
   function automatic logic [63:0] refResult(input logic [2:0] f, input bit w,
                                             input logic [63:0] a, input logic [63:0] b);
      logic [31:0]  a32, b32, t32;
      logic [127:0] p;
      int           sa32, sb32;
      longint       sa, sb;
      logic [63:0]  r;
      a32 = a[31:0];
      b32 = b[31:0];
      sa32 = a32;
      sb32 = b32;
      sa = a;
      sb = b;
      r = '0;
      if (w) begin
         case (f)
            3'd0: begin t32 = a32 * b32; r = sx32(t32); end
            3'd4: begin
               if (b32 == 0) r = '1;
               else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r = sx32(a32);
               else begin t32 = sa32 / sb32; r = sx32(t32); end
            end
            3'd5: begin
               if (b32 == 0) r = '1;
               else begin t32 = a32 / b32; r = sx32(t32); end
            end
            3'd6: begin
               if (b32 == 0) r = sx32(a32);
               else if (a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) r = '0;
               else begin t32 = sa32 % sb32; r = sx32(t32); end
            end
            3'd7: begin
               if (b32 == 0) r = sx32(a32);
               else begin t32 = a32 % b32; r = sx32(t32); end
            end
            default: r = '0;
         endcase
      end else begin
         case (f)
            3'd0: r = a * b;
            3'd1: begin p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = p[127:64]; end
            3'd2: begin p = {{64{a[63]}}, a} * {64'b0, b}; r = p[127:64]; end
            3'd3: begin p = {64'b0, a} * {64'b0, b}; r = p[127:64]; end
            3'd4: begin
               if (b == 0) r = '1;
               else if (a == 64'h8000_0000_0000_0000 && b == '1) r = a;
               else r = sa / sb;
            end
            3'd5: r = (b == 0) ? '1 : a / b;
            3'd6: begin
               if (b == 0) r = a;
               else if (a == 64'h8000_0000_0000_0000 && b == '1) r = '0;
               else r = sa % sb;
            end
            default: r = (b == 0) ? a : a % b;
         endcase
      end
      return r;
   endfunction

   // Cycles from accept to out_valid: special divides return at once,
   // everything else pays the full or word iteration count plus two.
   function automatic int refLatency(input logic [2:0] f, input bit w,
                                     input logic [63:0] a, input logic [63:0] b);
      bit bz, ov;
      if (f[2]) begin
         bz = w ? (b[31:0] == 0) : (b == 0);
         ov = !f[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                          : (a == 64'h8000_0000_0000_0000 && b == '1));
         if (bz || ov) return LAT_SPECIAL;
      end
      return w ? LAT_WORD : LAT_FULL;
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom(), $urandom()};
   endfunction

   // Drive one request into an idle unit, wait (bounded) for its result and
   // report the result and the observed latency. With doPop the result is
   // consumed before returning, leaving the unit idle again.
   task automatic applyStimulus(input logic [2:0] f, input bit w,
                                input logic [63:0] a, input logic [63:0] b,
                                input bit doPop,
                                output logic [63:0] res, output int lat,
                                output bit timedOut);
      @(negedge clk);
      in_func3 = f;
      in_word  = w;
      rs1      = a;
      rs2      = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
      timedOut = (out_valid !== 1'b1);
      res = out_result;
      if (doPop && !timedOut) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Reset brings the unit up idle with a cleared result
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
      end
      checks++;
      if (out_result !== 64'd0) begin
         errors++;
         $display("[TB] FAIL reset_out_result: got %h expected 0", out_result);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_busy: got %b expected 0", busy);
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
      end
   endtask

   // Hand-picked vectors with known answers, including the special divides
   typedef struct {
      logic [2:0]  f;
      bit          w;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
      int          lat;
   } vec_t;

   task automatic test_known_vectors();
      vec_t        v[14];
      logic [63:0] res;
      int          lat;
      bit          to;
      v[0]  = '{3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 66};
      v[1]  = '{3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000, 66};
      v[2]  = '{3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 66};
      v[3]  = '{3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66};
      v[4]  = '{3'd4, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1};
      v[5]  = '{3'd6, 1'b0, 64'd5, 64'd0, 64'd5, 1};
      v[6]  = '{3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1};
      v[7]  = '{3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1};
      v[8]  = '{3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34};
      v[9]  = '{3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34};
      v[10] = '{3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 64'h0000_0000_7FFF_FFFF, 34};
      v[11] = '{3'd1, 1'b1, 64'd5, 64'd6, 64'd0, 34};
      v[12] = '{3'd7, 1'b1, 64'h1234_5678_8000_0001, 64'hABCD_0000_0000_0000, 64'hFFFF_FFFF_8000_0001, 1};
      v[13] = '{3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1};
      for (int i = 0; i < 14; i++) begin
         applyStimulus(v[i].f, v[i].w, v[i].a, v[i].b, 1'b1, res, lat, to);
         checks++;
         if (to) begin
            errors++;
            $display("[TB] FAIL vector%0d_timeout: got no out_valid expected out_valid", i);
         end
         checks++;
         if (res !== v[i].exp) begin
            errors++;
            $display("[TB] FAIL vector%0d_result: got %h expected %h", i, res, v[i].exp);
         end
         checks++;
         if (lat != v[i].lat) begin
            errors++;
            $display("[TB] FAIL vector%0d_latency: got %0d expected %0d", i, lat, v[i].lat);
         end
      end
   endtask

   // Random operations of every kind against the reference model, with a
   // bias towards the divide corner cases
   task automatic test_random_ops();
      logic [2:0]  f;
      bit          w;
      logic [63:0] a, b, res, exp;
      int          lat, kind;
      bit          to;
      for (int i = 0; i < 60; i++) begin
         f = 3'($urandom_range(0, 7));
         w = 1'($urandom_range(0, 1));
         a = rnd64();
         b = rnd64();
         kind = $urandom_range(0, 9);
         case (kind)
            0: b = w ? {b[63:32], 32'd0} : 64'd0;
            1: begin a = 64'h8000_0000_0000_0000; b = '1; end
            2: begin a = {a[63:32], 32'h8000_0000}; b = {b[63:32], 32'hFFFF_FFFF}; end
            3: b = 64'($urandom_range(1, 15));
            4: a = 64'($urandom_range(0, 15));
            default: ;
         endcase
         exp = refResult(f, w, a, b);
         applyStimulus(f, w, a, b, 1'b1, res, lat, to);
         checks++;
         if (to || res !== exp) begin
            errors++;
            $display("[TB] FAIL random%0d_result f3=%0d w=%0d a=%h b=%h: got %h expected %h",
                     i, f, w, a, b, res, exp);
         end
         checks++;
         if (lat != refLatency(f, w, a, b)) begin
            errors++;
            $display("[TB] FAIL random%0d_latency: got %0d expected %0d", i, lat, refLatency(f, w, a, b));
         end
      end
   endtask

   // A result held under backpressure must stay put and block new issues
   task automatic test_backpressure();
      logic [63:0] a, b, res, exp;
      int          lat;
      bit          to;
      a = rnd64();
      b = rnd64();
      exp = refResult(3'd3, 1'b0, a, b);
      out_ready = 1'b0;
      applyStimulus(3'd3, 1'b0, a, b, 1'b0, res, lat, to);
      checks++;
      if (to || res !== exp) begin
         errors++;
         $display("[TB] FAIL bp_result: got %h expected %h", res, exp);
      end
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_result !== exp || in_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_hold%0d: got valid=%b result=%h in_ready=%b expected valid=1 result=%h in_ready=0",
                     c, out_valid, out_result, in_ready, exp);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 64'd0) begin
         errors++;
         $display("[TB] FAIL bp_pop: got valid=%b in_ready=%b result=%h expected valid=0 in_ready=1 result=0",
                  out_valid, in_ready, out_result);
      end
   endtask

   // Kill a DIVU twenty cycles in, either with flush or with reset. Nothing
   // may come out afterwards, and the next multiply must still be correct.
   task automatic test_flush(input bit useRst);
      logic [63:0] res;
      int          lat, seen;
      bit          to;
      @(negedge clk);
      in_func3 = 3'd5;
      in_word  = 1'b0;
      rs1      = rnd64();
      rs2      = rnd64() | 64'd1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (19) @(posedge clk);
      @(negedge clk);
      if (useRst) rst = 1'b1;
      else flush = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      flush = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 64'd0) begin
         errors++;
         $display("[TB] FAIL kill%0d_idle: got busy=%b valid=%b in_ready=%b result=%h expected busy=0 valid=0 in_ready=1 result=0",
                  useRst, busy, out_valid, in_ready, out_result);
      end
      seen = 0;
      repeat (80) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("[TB] FAIL kill%0d_no_result: got %0d valid cycles expected 0", useRst, seen);
      end
      applyStimulus(3'd0, 1'b0, 64'd3, 64'd4, 1'b1, res, lat, to);
      checks++;
      if (to || res !== 64'd12 || lat != LAT_FULL) begin
         errors++;
         $display("[TB] FAIL kill%0d_next_mul: got %h lat %0d expected 12 lat %0d", useRst, res, lat, LAT_FULL);
      end
   endtask

   // Flushing a result that is waiting in DONE throws it away
   task automatic test_flush_done();
      logic [63:0] res;
      int          lat;
      bit          to;
      out_ready = 1'b0;
      applyStimulus(3'd4, 1'b0, 64'd9, 64'd0, 1'b0, res, lat, to);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      out_ready = 1'b1;
      #1;
      checks++;
      if (to || out_valid !== 1'b0 || out_result !== 64'd0 || in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL flush_done: got valid=%b result=%h in_ready=%b expected valid=0 result=0 in_ready=1",
                  out_valid, out_result, in_ready);
      end
   endtask

   // Issue operations back to back as fast as the handshake allows
   task automatic test_back_to_back();
      logic [2:0]  f;
      bit          w;
      logic [63:0] a, b, res, exp;
      int          lat;
      bit          to;
      for (int i = 0; i < 8; i++) begin
         f = 3'($urandom_range(0, 7));
         w = 1'(i % 2);
         a = rnd64();
         b = rnd64();
         exp = refResult(f, w, a, b);
         applyStimulus(f, w, a, b, 1'b1, res, lat, to);
         checks++;
         if (to || res !== exp) begin
            errors++;
            $display("[TB] FAIL b2b%0d_result: got %h expected %h", i, res, exp);
         end
         checks++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b%0d_after_pop: got in_ready=%b valid=%b expected in_ready=1 valid=0",
                     i, in_ready, out_valid);
         end
      end
   endtask

   // Main sequence
   initial begin
      errors    = 0;
      checks    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_func3  = 3'd0;
      in_word   = 1'b0;
      rs1       = '0;
      rs2       = '0;
      flush     = 1'b0;
      out_ready = 1'b1;
      test_reset();
      test_known_vectors();
      test_random_ops();
      test_backpressure();
      test_flush(1'b0);
      test_flush(1'b1);
      test_flush_done();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
